// File: rtl/counter_pkg.sv
// Shared types and mode constants for the up/down counter family.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable modulus, clear/load,
// wrap or saturate at the bounds, and a zero-latency cascade carry (tc).
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_COUNT   = 2**WIDTH - 1,
  parameter int SATURATE    = CNT_WRAP,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  if (WIDTH < 1) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be >= 1");
  end
  if (MAX_COUNT < 0 || longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("counter_updown_mod: MAX_COUNT out of range for WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE > MAX_COUNT) begin : g_bad_reset
    $error("counter_updown_mod: RESET_VALUE must lie in 0..MAX_COUNT");
  end

  count_dir_e       dir;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign dir      = count_dir_e'(up_dn);
  assign at_limit = (dir == DIR_UP) ? (q == MAX_V) : (q == '0);
  assign tc       = enable & at_limit & ~clear & ~load;

  // Bound check comes before +/-1, so a short modulus never rolls through 2**WIDTH.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (clear) begin
      q_next = RST_V;
    end else if (load) begin
      q_next = (load_value > MAX_V) ? MAX_V : load_value;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        if (q < MAX_V) begin
          q_next = q + WIDTH'(1);
        end else if (SATURATE != CNT_SAT) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (q > '0) begin
          q_next = q - WIDTH'(1);
        end else if (SATURATE != CNT_SAT) begin
          q_next    = MAX_V;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RST_V;
      wrapped <= 1'b0;
    end else begin
      q       <= q_next;
      wrapped <= wrap_next;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench: decade, saturating and two-digit cascade counters
// compared every cycle against an integer model, plus directed literal checks.
module tb_counter_updown_mod;

  logic clk;
  logic reset;

  // Decade counter (MAX_COUNT=9, wrap)
  logic       clrD, ldD, enD, upD;
  logic [3:0] lvD;
  logic [3:0] qDec;
  logic       tcDec, wrDec, alDec;

  // Saturating counter (MAX_COUNT=15)
  logic       clrS, ldS, enS, upS;
  logic [3:0] lvS;
  logic [3:0] qSat;
  logic       tcSat, wrSat, alSat;

  // Two-stage decade cascade
  logic       enC;
  logic [3:0] q0, q1;
  logic       tc0, tc1, wr0, wr1, al0, al1;

  int checks = 0;
  int errors = 0;
  bit checking = 0;
  int wrap1Count = 0;

  int mDec, mSat, mCas;
  bit wDec, wSat, w0, w1;

  counter_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .RESET_VALUE(0)) dutDec (
    .clk(clk), .reset(reset), .clear(clrD), .load(ldD), .load_value(lvD),
    .enable(enD), .up_dn(upD), .q(qDec), .tc(tcDec), .wrapped(wrDec), .at_limit(alDec));

  counter_updown_mod #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1), .RESET_VALUE(0)) dutSat (
    .clk(clk), .reset(reset), .clear(clrS), .load(ldS), .load_value(lvS),
    .enable(enS), .up_dn(upS), .q(qSat), .tc(tcSat), .wrapped(wrSat), .at_limit(alSat));

  counter_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .RESET_VALUE(0)) stage0 (
    .clk(clk), .reset(reset), .clear(1'b0), .load(1'b0), .load_value(4'd0),
    .enable(enC), .up_dn(1'b1), .q(q0), .tc(tc0), .wrapped(wr0), .at_limit(al0));

  counter_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .RESET_VALUE(0)) stage1 (
    .clk(clk), .reset(reset), .clear(1'b0), .load(1'b0), .load_value(4'd0),
    .enable(tc0), .up_dn(1'b1), .q(q1), .tc(tc1), .wrapped(wr1), .at_limit(al1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int edges);
    repeat (edges) @(negedge clk);
    #1;
  endtask

  function automatic void stepModel(input int maxc, input bit sat, input bit clr, input bit ld,
                                     input int lv, input bit en, input bit up, input int cur,
                                     output int nxt, output bit w);
    w   = 1'b0;
    nxt = cur;
    if (clr) nxt = 0;
    else if (ld) nxt = (lv > maxc) ? maxc : lv;
    else if (en) begin
      if (up) begin
        if (cur < maxc) nxt = cur + 1;
        else if (!sat) begin nxt = 0; w = 1'b1; end
      end else begin
        if (cur > 0) nxt = cur - 1;
        else if (!sat) begin nxt = maxc; w = 1'b1; end
      end
    end
  endfunction

  // Reference model: counts as plain integers, cascade as a single 0..99 value.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mDec = 0; wDec = 0; mSat = 0; wSat = 0; mCas = 0; w0 = 0; w1 = 0;
    end else begin
      stepModel(9, 1'b0, clrD, ldD, int'(lvD), enD, upD, mDec, mDec, wDec);
      stepModel(15, 1'b1, clrS, ldS, int'(lvS), enS, upS, mSat, mSat, wSat);
      if (enC) begin
        w0   = (mCas % 10 == 9);
        w1   = (mCas == 99);
        mCas = (mCas + 1) % 100;
      end else begin
        w0 = 1'b0;
        w1 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("dec_q", int'(qDec), mDec);
      checkOutput("dec_wrapped", int'(wrDec), int'(wDec));
      checkOutput("dec_at_limit", int'(alDec), int'(upD ? (mDec == 9) : (mDec == 0)));
      checkOutput("dec_tc", int'(tcDec),
                  int'(enD && !clrD && !ldD && (upD ? (mDec == 9) : (mDec == 0))));
      checkOutput("sat_q", int'(qSat), mSat);
      checkOutput("sat_wrapped", int'(wrSat), int'(wSat));
      checkOutput("sat_at_limit", int'(alSat), int'(upS ? (mSat == 15) : (mSat == 0)));
      checkOutput("sat_tc", int'(tcSat),
                  int'(enS && !clrS && !ldS && (upS ? (mSat == 15) : (mSat == 0))));
      checkOutput("cas_q0", int'(q0), mCas % 10);
      checkOutput("cas_q1", int'(q1), mCas / 10);
      checkOutput("cas_wr0", int'(wr0), int'(w0));
      checkOutput("cas_wr1", int'(wr1), int'(w1));
      checkOutput("cas_tc0", int'(tc0), int'(enC && (mCas % 10 == 9)));
      checkOutput("cas_tc1", int'(tc1), int'(enC && (mCas == 99)));
      checkOutput("cas_al0", int'(al0), int'(mCas % 10 == 9));
      checkOutput("cas_al1", int'(al1), int'(mCas / 10 == 9));
      if (wr1) wrap1Count++;
    end
  end

  initial begin
    reset = 1'b0;
    clrD = 0; ldD = 0; enD = 0; upD = 1; lvD = '0;
    clrS = 0; ldS = 0; enS = 0; upS = 1; lvS = '0;
    enC = 0;
    applyStimulus(2);
    reset = 1'b1;
    checking = 1'b1;
    checkOutput("reset_q", int'(qDec), 0);

    // Asynchronous reset mid-count, then clear beating load.
    enD = 1;
    applyStimulus(5);
    checkOutput("count_to_5", int'(qDec), 5);
    enD = 0;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_q", int'(qDec), 0);
    checkOutput("async_reset_wrapped", int'(wrDec), 0);
    #2;
    reset = 1'b1;
    applyStimulus(1);
    clrD = 1; ldD = 1; lvD = 4'd7; enD = 1;
    applyStimulus(1);
    checkOutput("clear_beats_load", int'(qDec), 0);
    clrD = 0; ldD = 0; enD = 0;

    // Decade wrap up.
    enD = 1; upD = 1;
    applyStimulus(9);
    checkOutput("decade_at_9", int'(qDec), 9);
    checkOutput("decade_tc_at_9", int'(tcDec), 1);
    applyStimulus(1);
    checkOutput("decade_wrap_q", int'(qDec), 0);
    checkOutput("decade_wrap_pulse", int'(wrDec), 1);
    enD = 0;

    // Load clamp and wrap down.
    ldD = 1; lvD = 4'd12;
    applyStimulus(1);
    checkOutput("load_clamp", int'(qDec), 9);
    ldD = 0; clrD = 1;
    applyStimulus(1);
    clrD = 0; upD = 0; enD = 1;
    applyStimulus(1);
    checkOutput("wrap_down_q", int'(qDec), 9);
    checkOutput("wrap_down_pulse", int'(wrDec), 1);
    enD = 0; upD = 1;

    // Enable gating and direction flip.
    ldD = 1; lvD = 4'd6;
    applyStimulus(1);
    ldD = 0;
    applyStimulus(3);
    checkOutput("hold_at_6", int'(qDec), 6);
    enD = 1; upD = 1;
    applyStimulus(1);
    checkOutput("up_to_7", int'(qDec), 7);
    upD = 0;
    applyStimulus(1);
    checkOutput("down_to_6", int'(qDec), 6);
    enD = 0; upD = 1;

    // Saturation at both bounds.
    ldS = 1; lvS = 4'd14;
    applyStimulus(1);
    ldS = 0; enS = 1; upS = 1;
    applyStimulus(1);
    checkOutput("sat_reach_15", int'(qSat), 15);
    applyStimulus(3);
    checkOutput("sat_hold_15", int'(qSat), 15);
    checkOutput("sat_tc_held", int'(tcSat), 1);
    checkOutput("sat_al_held", int'(alSat), 1);
    checkOutput("sat_no_wrap", int'(wrSat), 0);
    upS = 0; ldS = 1; lvS = 4'd0;
    applyStimulus(1);
    ldS = 0;
    applyStimulus(3);
    checkOutput("sat_hold_0", int'(qSat), 0);
    enS = 0; upS = 1;

    // Two-digit cascade through a full 00..99 cycle.
    enC = 1;
    applyStimulus(99);
    checkOutput("cascade_99_hi", int'(q1), 9);
    checkOutput("cascade_99_lo", int'(q0), 9);
    applyStimulus(1);
    checkOutput("cascade_00_hi", int'(q1), 0);
    checkOutput("cascade_00_lo", int'(q0), 0);
    enC = 0;
    applyStimulus(1);
    checkOutput("cascade_wrap_once", wrap1Count, 1);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
